// File: rtl/rs_iter_div_pkg.sv
// Shared types and constants for the iterative restoring divider.
package rs_iter_div_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StDone = 2'd2
    } state_e;

    // Quotient reported for a zero divisor; callers slice to their width.
    localparam logic [63:0] DivZeroQuot = '1;

    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/rs_sub_slice.sv
// Combinational trial subtract a - b as a + ~b + 1; carry-out high means no borrow.
module rs_sub_slice #(
    parameter int unsigned WIDTH = 33
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             no_borrow
);

    logic [WIDTH:0] sum;

    assign sum       = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    assign diff      = sum[WIDTH-1:0];
    assign no_borrow = sum[WIDTH];

endmodule

// File: rtl/rs_iter_div.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, valid/ready on both sides.
module rs_iter_div
    import rs_iter_div_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   d_q, d_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quot_q, quot_d;
    logic [WIDTH-1:0]   remo_q, remo_d;
    logic               dbz_q, dbz_d;

    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     trial;
    logic               no_borrow;
    logic               unused_trial_msb;

    assign shifted = {rem_q, q_q[WIDTH-1]};

    rs_sub_slice #(
        .WIDTH(WIDTH + 1)
    ) u_sub (
        .a        (shifted),
        .b        ({1'b0, d_q}),
        .diff     (trial),
        .no_borrow(no_borrow)
    );

    // Top bit of the difference is always zero whenever it is selected.
    assign unused_trial_msb = trial[WIDTH];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        d_d     = d_q;
        q_d     = q_q;
        rem_d   = rem_q;
        quot_d  = quot_q;
        remo_d  = remo_q;
        dbz_d   = dbz_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    d_d   = divisor;
                    q_d   = dividend;
                    rem_d = '0;
                    cnt_d = CNT_W'(WIDTH - 1);
                    if (divisor == '0) begin
                        state_d = StDone;
                        quot_d  = DivZeroQuot[WIDTH-1:0];
                        remo_d  = dividend;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = StCalc;
                        dbz_d   = 1'b0;
                    end
                end
            end
            StCalc: begin
                rem_d = no_borrow ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
                q_d   = {q_q[WIDTH-2:0], no_borrow};
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    state_d = StDone;
                    quot_d  = q_d;
                    remo_d  = rem_d;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            d_q     <= '0;
            q_q     <= '0;
            rem_q   <= '0;
            quot_q  <= '0;
            remo_q  <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            d_q     <= d_d;
            q_q     <= q_d;
            rem_q   <= rem_d;
            quot_q  <= quot_d;
            remo_q  <= remo_d;
            dbz_q   <= dbz_d;
        end
    end

    assign in_ready    = (state_q == StIdle);
    assign out_valid   = (state_q == StDone);
    assign quotient    = quot_q;
    assign remainder   = remo_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_rs_iter_div.sv
// Directed bench for rs_iter_div at WIDTH=32 plus an exhaustive WIDTH=4 sweep.
module tb_rs_iter_div;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b1, a_dbz;
    logic [31:0] a_dividend = '0, a_divisor = '0, a_quotient, a_remainder;

    logic        b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b1, b_dbz;
    logic [3:0]  b_dividend = '0, b_divisor = '0, b_quotient, b_remainder;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rs_iter_div #(.WIDTH(32)) u_dut32 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (a_in_valid),
        .in_ready   (a_in_ready),
        .dividend   (a_dividend),
        .divisor    (a_divisor),
        .out_valid  (a_out_valid),
        .out_ready  (a_out_ready),
        .quotient   (a_quotient),
        .remainder  (a_remainder),
        .div_by_zero(a_dbz)
    );

    rs_iter_div #(.WIDTH(4)) u_dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (b_in_valid),
        .in_ready   (b_in_ready),
        .dividend   (b_dividend),
        .divisor    (b_divisor),
        .out_valid  (b_out_valid),
        .out_ready  (b_out_ready),
        .quotient   (b_quotient),
        .remainder  (b_remainder),
        .div_by_zero(b_dbz)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Entered at a negedge; lat counts edges from the accept edge (=1) to out_valid.
    task automatic run32(input logic [31:0] x, input logic [31:0] y, output int lat);
        a_dividend = x;
        a_divisor  = y;
        a_in_valid = 1'b1;
        chk("a_in_ready_pre", 64'(a_in_ready), 64'd1);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            a_in_valid = 1'b0;
        end while (!a_out_valid && lat < 100);
    endtask

    task automatic job32(input string tag, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] eq, input logic [31:0] er, input logic edbz,
                         input int elat);
        int lat;
        run32(x, y, lat);
        chk({tag, "_lat"}, 64'(lat), 64'(elat));
        chk({tag, "_q"}, 64'(a_quotient), 64'(eq));
        chk({tag, "_r"}, 64'(a_remainder), 64'(er));
        chk({tag, "_dbz"}, 64'(a_dbz), 64'(edbz));
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_ov_after"}, 64'(a_out_valid), 64'd0);
        chk({tag, "_ir_after"}, 64'(a_in_ready), 64'd1);
    endtask

    task automatic job4(input int x, input int y);
        int lat;
        logic [3:0] eq, er;
        int elat;
        if (y == 0) begin
            eq = 4'hF; er = 4'(x); elat = 1;
        end else begin
            eq = 4'(x / y); er = 4'(x % y); elat = 5;
        end
        b_dividend = 4'(x);
        b_divisor  = 4'(y);
        b_in_valid = 1'b1;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            b_in_valid = 1'b0;
        end while (!b_out_valid && lat < 20);
        chk($sformatf("w4_%0d_%0d_lat", x, y), 64'(lat), 64'(elat));
        chk($sformatf("w4_%0d_%0d_q", x, y), 64'(b_quotient), 64'(eq));
        chk($sformatf("w4_%0d_%0d_r", x, y), 64'(b_remainder), 64'(er));
        chk($sformatf("w4_%0d_%0d_dbz", x, y), 64'(b_dbz), 64'(y == 0));
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int lat;
        int seen;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ov", 64'(a_out_valid), 64'd0);
        chk("rst_q", 64'(a_quotient), 64'd0);
        chk("rst_r", 64'(a_remainder), 64'd0);
        chk("rst_dbz", 64'(a_dbz), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ir", 64'(a_in_ready), 64'd1);

        // 1-3: basic, divide by zero, boundary operands
        job32("t1", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);
        job32("t2", 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 1);
        job32("t3a", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 33);
        job32("t3b", 32'd5, 32'd9, 32'd0, 32'd5, 1'b0, 33);
        job32("t3c", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 33);

        // 4: backpressure with a competing request during the stall
        a_out_ready = 1'b0;
        run32(32'd1000, 32'd10, lat);
        chk("t4_lat", 64'(lat), 64'd33);
        a_in_valid = 1'b1;
        a_dividend = 32'd7;
        a_divisor  = 32'd1;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t4_ov_%0d", i), 64'(a_out_valid), 64'd1);
            chk($sformatf("t4_q_%0d", i), 64'(a_quotient), 64'd100);
            chk($sformatf("t4_r_%0d", i), 64'(a_remainder), 64'd0);
            chk($sformatf("t4_ir_%0d", i), 64'(a_in_ready), 64'd0);
            @(posedge clk);
            @(negedge clk);
        end
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        chk("t4_ov_6", 64'(a_out_valid), 64'd1);
        @(posedge clk);
        @(negedge clk);
        chk("t4_ov_after", 64'(a_out_valid), 64'd0);
        chk("t4_ir_after", 64'(a_in_ready), 64'd1);
        chk("t4_q_retained", 64'(a_quotient), 64'd100);

        // 5: reset in the middle of the iterations
        a_dividend = 32'd81;
        a_divisor  = 32'd9;
        a_in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a_in_valid = 1'b0;
        chk("t5_ir_busy", 64'(a_in_ready), 64'd0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t5_ov_rst", 64'(a_out_valid), 64'd0);
        chk("t5_q_rst", 64'(a_quotient), 64'd0);
        chk("t5_r_rst", 64'(a_remainder), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t5_ir_release", 64'(a_in_ready), 64'd1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (a_out_valid) seen++;
        end
        chk("t5_no_result", 64'(seen), 64'd0);
        job32("t5_new", 32'd81, 32'd9, 32'd9, 32'd0, 1'b0, 33);

        // 6: exhaustive 4-bit sweep
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                job4(x, y);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
